// File: rtl/serial_sequencer.sv
// rtl/serial_sequencer.sv - sequencing controller for the bit-serial R-type datapath
module serial_sequencer #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        ins_bit,
    output logic        fetch_en,
    output logic [4:0]  bit_cnt,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [3:0]  alu_op,
    output logic        exec_en,
    output logic        alu_first,
    output logic        alu_last,
    output logic        rd_we,
    output logic        pc_inc,
    output logic        busy,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_COMMIT,
        S_HALT
    } state_t;

    localparam logic [4:0] FETCH_LAST = 5'd31;
    localparam logic [4:0] EXEC_LAST  = 5'(XLEN - 1);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_ir;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [3:0]  r_alu_op;
    logic        r_illegal;
    logic [31:0] r_instret;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_legal;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];

    // Shifts are excluded: the serial ALU has no shifter.
    always_comb begin
        w_legal = 1'b0;
        if (w_opcode == 7'b0110011) begin
            if (w_funct7 == 7'b0000000)
                w_legal = (w_funct3 != 3'b001) && (w_funct3 != 3'b101);
            else if (w_funct7 == 7'b0100000)
                w_legal = (w_funct3 == 3'b000);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (r_bit_cnt == FETCH_LAST) w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC:   if (r_bit_cnt == EXEC_LAST) w_next = S_COMMIT;
            S_COMMIT: w_next = run ? S_FETCH : S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt <= '0;
            r_ir      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_alu_op  <= '0;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            // Counter only advances while staying inside FETCH or EXEC, so every phase starts at 0.
            if ((r_state == S_FETCH && w_next == S_FETCH) ||
                (r_state == S_EXEC  && w_next == S_EXEC))
                r_bit_cnt <= r_bit_cnt + 5'd1;
            else
                r_bit_cnt <= '0;

            if (r_state == S_FETCH)
                r_ir[r_bit_cnt] <= ins_bit;

            if (r_state == S_DECODE) begin
                if (w_legal) begin
                    r_rs1    <= r_ir[19:15];
                    r_rs2    <= r_ir[24:20];
                    r_rd     <= r_ir[11:7];
                    r_alu_op <= {r_ir[30], r_ir[14:12]};
                end else begin
                    r_illegal <= 1'b1;
                end
            end

            if (r_state == S_COMMIT)
                r_instret <= r_instret + 32'd1;
        end
    end

    assign fetch_en  = (r_state == S_FETCH);
    assign exec_en   = (r_state == S_EXEC);
    assign alu_first = exec_en && (r_bit_cnt == 5'd0);
    assign alu_last  = exec_en && (r_bit_cnt == EXEC_LAST);
    assign rd_we     = exec_en && (r_rd != 5'd0);
    assign pc_inc    = (r_state == S_COMMIT);
    assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bit_cnt   = r_bit_cnt;
    assign rs1_addr  = r_rs1;
    assign rs2_addr  = r_rs2;
    assign rd_addr   = r_rd;
    assign alu_op    = r_alu_op;
    assign illegal   = r_illegal;
    assign instret   = r_instret;

endmodule

// File: tb/tb_serial_sequencer.sv
// tb/tb_serial_sequencer.sv - table-driven self-checking bench for serial_sequencer
module tb_serial_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        ins_bit;
    logic        fetch_en;
    logic [4:0]  bit_cnt;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_op;
    logic        exec_en;
    logic        alu_first;
    logic        alu_last;
    logic        rd_we;
    logic        pc_inc;
    logic        busy;
    logic        illegal;
    logic [31:0] instret;

    serial_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .run(run), .ins_bit(ins_bit),
        .fetch_en(fetch_en), .bit_cnt(bit_cnt),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_op(alu_op), .exec_en(exec_en), .alu_first(alu_first),
        .alu_last(alu_last), .rd_we(rd_we), .pc_inc(pc_inc),
        .busy(busy), .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  op;
        int          n_we;
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] prog[4];
    int          prog_len;
    int          prog_idx;
    int          cyc;
    int          n_fetch, n_exec, n_we, n_first, n_last, n_pc, n_bad_fl;
    int          pc_cyc[4];
    logic [3:0]  op_seen[4];
    logic [4:0]  rd_seen[4];
    int          errors;
    int          checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        cyc = 0; prog_idx = 0;
        n_fetch = 0; n_exec = 0; n_we = 0; n_first = 0; n_last = 0; n_pc = 0; n_bad_fl = 0;
    endtask

    // One clock: sample on the falling edge, then present the next instruction bit.
    task automatic tick();
        logic [31:0] w;
        @(negedge clk);
        cyc++;
        if (fetch_en) n_fetch++;
        if (exec_en) n_exec++;
        if (rd_we) n_we++;
        if (alu_first && n_first < 4) begin
            op_seen[n_first] = alu_op;
            rd_seen[n_first] = rd_addr;
        end
        if (alu_first) begin
            n_first++;
            if (bit_cnt != 5'd0) n_bad_fl++;
        end
        if (alu_last) begin
            n_last++;
            if (bit_cnt != 5'd31) n_bad_fl++;
        end
        if (pc_inc) begin
            if (n_pc < 4) pc_cyc[n_pc] = cyc;
            n_pc++;
        end
        ins_bit = 1'b0;
        if (fetch_en && prog_idx < prog_len) begin
            w = prog[prog_idx];
            ins_bit = w[bit_cnt];
            if (bit_cnt == 5'd31) prog_idx++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        ins_bit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        run = 1'b0;
        ins_bit = 1'b0;
        prog_len = 0;
        clear_counts();

        vecs[0] = '{32'h002081B3, 1'b0, 5'd1, 5'd2, 5'd3, 4'b0000, 32};
        vecs[1] = '{32'h407302B3, 1'b0, 5'd6, 5'd7, 5'd5, 4'b1000, 32};
        vecs[2] = '{32'h0020C233, 1'b0, 5'd1, 5'd2, 5'd4, 4'b0100, 32};
        vecs[3] = '{32'h00208033, 1'b0, 5'd1, 5'd2, 5'd0, 4'b0000, 0};
        vecs[4] = '{32'h00000013, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 0};
        vecs[5] = '{32'h002091B3, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 0};
        vecs[6] = '{32'h0020D1B3, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 0};
        vecs[7] = '{32'h4020F1B3, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 0};
        vecs[8] = '{32'h022081B3, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 0};

        #3;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_strobes", {26'd0, fetch_en, exec_en, rd_we, pc_inc, illegal, alu_first}, 32'd0);
        check("reset_fields", {12'd0, rs1_addr, rs2_addr, rd_addr, alu_op}, 32'd0);

        // Each vector: single instruction from reset, run dropped during FETCH.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            prog[0] = vecs[v].ins;
            prog_len = 1;
            clear_counts();
            run = 1'b1;
            tick();
            run = 1'b0;
            for (int c = 0; c < 139; c++) tick();
            check($sformatf("v%0d_illegal", v), {31'd0, illegal}, {31'd0, vecs[v].ill});
            check($sformatf("v%0d_fields", v), {12'd0, rs1_addr, rs2_addr, rd_addr, alu_op},
                  {12'd0, vecs[v].rs1, vecs[v].rs2, vecs[v].rd, vecs[v].op});
            check($sformatf("v%0d_fetch_cycles", v), n_fetch, 32);
            check($sformatf("v%0d_exec_cycles", v), n_exec, vecs[v].ill ? 0 : 32);
            check($sformatf("v%0d_rd_we_cycles", v), n_we, vecs[v].n_we);
            check($sformatf("v%0d_pc_inc", v), n_pc, vecs[v].ill ? 0 : 1);
            check($sformatf("v%0d_instret", v), instret, vecs[v].ill ? 0 : 1);
            check($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
            if (!vecs[v].ill) begin
                check($sformatf("v%0d_pc_cycle", v), pc_cyc[0], 66);
                check($sformatf("v%0d_first_last", v), {n_first[7:0], n_last[7:0], n_bad_fl[7:0]},
                      {8'd1, 8'd1, 8'd0});
            end
        end

        // SUB then XOR back-to-back with run held high.
        do_reset();
        prog[0] = 32'h407302B3;
        prog[1] = 32'h0020C233;
        prog_len = 2;
        clear_counts();
        run = 1'b1;
        for (int c = 0; c < 200 && n_pc < 2; c++) tick();
        run = 1'b0;
        check("b2b_pc_count", n_pc, 2);
        check("b2b_pc_cycles", {pc_cyc[0][15:0], pc_cyc[1][15:0]}, {16'd66, 16'd132});
        check("b2b_alu_op", {op_seen[0], op_seen[1]}, {4'b1000, 4'b0100});
        check("b2b_rd", {rd_seen[0], rd_seen[1]}, {5'd5, 5'd4});
        for (int c = 0; c < 5; c++) tick();
        check("b2b_instret", instret, 32'd2);
        check("b2b_idle", {30'd0, busy, fetch_en}, 32'd0);

        // Re-asserting run from IDLE restarts FETCH on the next edge.
        prog[0] = 32'h002081B3;
        prog_len = 1;
        clear_counts();
        run = 1'b1;
        tick();
        check("restart_fetch", {26'd0, fetch_en, bit_cnt}, {26'd0, 1'b1, 5'd0});

        // Asynchronous reset mid-EXEC.
        for (int c = 0; c < 200 && !(exec_en && bit_cnt == 5'd10); c++) tick();
        check("mid_exec_reached", {31'd0, exec_en}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_strobes",
              {24'd0, fetch_en, exec_en, rd_we, pc_inc, illegal, alu_first, alu_last, busy}, 32'd0);
        check("async_rst_instret", instret, 32'd0);
        check("async_rst_fields", {7'd0, bit_cnt, rs1_addr, rs2_addr, rd_addr, alu_op}, 32'd0);
        run = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("post_rst_instret", instret, 32'd0);
        check("post_rst_no_pc", n_pc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
